// File: rtl/booth_mult_sched_pkg.sv
`default_nettype none
//==============================================================================
// booth_mult_sched_pkg : shared state encoding, default watchdog limit, helpers
// Revision: 1.0
//==============================================================================
package booth_mult_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam int DEF_TMO_CYC = 32;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/booth_mult_sched_rr_arbiter.sv
`default_nettype none
//==============================================================================
// booth_mult_sched_rr_arbiter : round-robin pick starting at ptr_i, wrapping
// Revision: 1.0
//==============================================================================
module booth_mult_sched_rr_arbiter
   import booth_mult_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int IDW    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDW-1:0]     ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDW-1:0]     gnt_idx_o,
   output logic               any_o
);

   always_comb begin
      int idx;
      gnt_o     = '0;
      gnt_idx_o = '0;
      any_o     = 1'b0;
      idx       = int'(ptr_i);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!any_o && req_i[IDW'(idx)]) begin
            any_o             = 1'b1;
            gnt_idx_o         = IDW'(idx);
            gnt_o[IDW'(idx)]  = 1'b1;
         end
         idx = wrap_inc(idx, NUM_REQ);
      end
   end

endmodule
`default_nettype wire

// File: rtl/booth_mult_sched.sv
`default_nettype none
//==============================================================================
// booth_mult_sched : round-robin sharing of one sequential multiplier core
// Revision: 1.0
//==============================================================================
module booth_mult_sched
   import booth_mult_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 4,
   parameter int TMO_CYC = DEF_TMO_CYC
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [NUM_REQ-1:0]       rsp_valid,
   output logic [2*WIDTH-1:0]       rsp_data,
   output logic                     rsp_err,
   output logic                     mul_start,
   output logic [WIDTH-1:0]         mul_a,
   output logic [WIDTH-1:0]         mul_b,
   output logic                     mul_rst,
   input  logic [2*WIDTH-1:0]       mul_product,
   input  logic                     mul_done,
   output logic                     busy
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int TW  = $clog2(TMO_CYC);

   state_t               state_q,  state_d;
   logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]       id_q,     id_d;
   logic [WIDTH-1:0]     a_q,      a_d;
   logic [WIDTH-1:0]     b_q,      b_d;
   logic [2*WIDTH-1:0]   prod_q,   prod_d;
   logic                 err_q,    err_d;
   logic [TW-1:0]        timer_q,  timer_d;

   logic [NUM_REQ-1:0]   gnt;
   logic [IDW-1:0]       gnt_idx;
   logic                 any;
   logic [WIDTH-1:0]     req_a_arr [NUM_REQ];
   logic [WIDTH-1:0]     req_b_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
      assign req_a_arr[i] = req_a[i*WIDTH +: WIDTH];
      assign req_b_arr[i] = req_b[i*WIDTH +: WIDTH];
   end

   booth_mult_sched_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req_i     (req_valid),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .any_o     (any)
   );

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      id_d     = id_q;
      a_d      = a_q;
      b_d      = b_q;
      prod_d   = prod_q;
      err_d    = err_q;
      timer_d  = timer_q;
      unique case (state_q)
         ST_IDLE: begin
            if (any) begin
               a_d      = req_a_arr[gnt_idx];
               b_d      = req_b_arr[gnt_idx];
               id_d     = gnt_idx;
               rr_ptr_d = IDW'(wrap_inc(int'(gnt_idx), NUM_REQ));
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            timer_d = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            timer_d = timer_q + TW'(1);
            // A completion arriving on the timeout cycle still counts as success.
            if (mul_done) begin
               prod_d  = mul_product;
               err_d   = 1'b0;
               state_d = ST_RESP;
            end else if (timer_q == TW'(TMO_CYC - 1)) begin
               prod_d  = '0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         id_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         prod_q   <= '0;
         err_q    <= 1'b0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         a_q      <= a_d;
         b_q      <= b_d;
         prod_q   <= prod_d;
         err_q    <= err_d;
         timer_q  <= timer_d;
      end
   end

   // The grant is combinational from req_valid, so it is masked while reset is held.
   assign req_ready = (state_q == ST_IDLE && rst_n) ? gnt : '0;
   assign rsp_valid = (state_q == ST_RESP) ? (NUM_REQ'(1) << id_q) : '0;
   assign rsp_data  = (state_q == ST_RESP && !err_q) ? prod_q : '0;
   assign rsp_err   = (state_q == ST_RESP) && err_q;
   assign mul_rst   = (state_q == ST_RESP) && err_q;
   assign mul_start = (state_q == ST_ISSUE);
   assign mul_a     = a_q;
   assign mul_b     = b_q;
   assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_sched.sv
`default_nettype none
//==============================================================================
// tb_booth_mult_sched : core stub, requester driver, timeline reference model
// Revision: 1.0
//==============================================================================
module tb_booth_mult_sched;

   localparam int N   = 4;
   localparam int W   = 4;
   localparam int PW  = 2 * W;
   localparam int TMO = 32;

   logic           clk       = 1'b0;
   logic           rst_n     = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_a     = '0;
   logic [N*W-1:0] req_b     = '0;
   logic [N-1:0]   req_ready, rsp_valid;
   logic [PW-1:0]  rsp_data, mul_product;
   logic           rsp_err, mul_start, mul_rst, busy, mul_done;
   logic [W-1:0]   mul_a, mul_b;
   logic           stub_done;
   logic           spur = 1'b0;

   assign mul_done = stub_done | spur;

   always #5 clk = ~clk;

   booth_mult_sched #(.NUM_REQ(N), .WIDTH(W), .TMO_CYC(TMO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .rsp_err     (rsp_err),
      .mul_start   (mul_start),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_rst     (mul_rst),
      .mul_product (mul_product),
      .mul_done    (mul_done),
      .busy        (busy)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
      int ia, ib;
      ia = int'($signed(a));
      ib = int'($signed(b));
      return PW'(ia * ib);
   endfunction

   function automatic int oh_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   // ---------------- multiplier core stub (signed product, variable latency)
   bit           hang      = 1'b0;
   int           lat_fixed = 0;
   int           stub_cnt;
   logic [W-1:0] sa, sb;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stub_cnt    <= 0;
         stub_done   <= 1'b0;
         mul_product <= '0;
         sa          <= '0;
         sb          <= '0;
      end else begin
         stub_done <= 1'b0;
         if (mul_rst) begin
            stub_cnt <= 0;
         end else if (mul_start) begin
            if (!hang) stub_cnt <= (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 14));
            sa <= mul_a;
            sb <= mul_b;
         end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
               stub_done   <= 1'b1;
               mul_product <= smul(sa, sb);
            end
         end
      end
   end

   // ---------------- requester driver
   int           req_tot [N] = '{default: 0};
   int           acc_cnt [N] = '{default: 0};
   logic [W-1:0] fix_a   [N] = '{default: '0};
   logic [W-1:0] fix_b   [N] = '{default: '0};
   bit           rnd_ops     = 1'b0;
   bit           withdraw_en = 1'b0;

   initial begin
      logic [W-1:0] ca [N];
      logic [W-1:0] cb [N];
      for (int i = 0; i < N; i++) begin
         ca[i] = '0;
         cb[i] = '0;
      end
      forever begin
         logic [N-1:0] rs;
         @(negedge clk);
         rs = req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (rs[i]) acc_cnt[i]++;
            if (!rnd_ops) begin
               ca[i] = fix_a[i];
               cb[i] = fix_b[i];
            end else if (rs[i]) begin
               ca[i] = W'($urandom);
               cb[i] = W'($urandom);
            end
            req_valid[i]     = (req_tot[i] > acc_cnt[i]) && !(withdraw_en && $urandom_range(0, 7) == 0);
            req_a[i*W +: W]  = ca[i];
            req_b[i*W +: W]  = cb[i];
         end
      end
   end

   // ---------------- reference model: one operation as a timeline
   // accept at cycle t, start at t+1, done window t+2..t+1+TMO, response the cycle after.
   int            mcyc = 0, m_acc = 0, m_resp = -1, m_id = 0, m_ptr = 0;
   bit            m_busy = 1'b0, m_err = 1'b0;
   logic [W-1:0]  m_a = '0, m_b = '0;
   logic [PW-1:0] m_prod = '0;
   int            rsp_cnt = 0, start_cnt = 0;
   int            tcyc = 0;

   always @(posedge clk) tcyc <= tcyc + 1;

   initial begin
      forever begin
         logic [N-1:0]  e_ready, e_rv;
         logic [PW-1:0] e_data;
         logic          e_err, e_start, e_rst;
         int            g;
         @(negedge clk);
         if (rsp_valid != 0) rsp_cnt++;
         if (mul_start) start_cnt++;
         if (!rst_n) begin
            m_busy = 1'b0; m_ptr = 0; m_a = '0; m_b = '0; m_resp = -1; mcyc = 0;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data",  rsp_data,  0);
            chk("rst_busy",      busy,      0);
            chk("rst_mul_start", mul_start, 0);
            chk("rst_mul_a",     mul_a,     0);
         end else begin
            e_ready = '0; e_rv = '0; e_data = '0; e_err = 1'b0; e_start = 1'b0; e_rst = 1'b0;
            g = -1;
            if (!m_busy) begin
               for (int k = 0; k < N; k++) begin
                  int j;
                  j = (m_ptr + k) % N;
                  if (g < 0 && req_valid[j]) g = j;
               end
               if (g >= 0) e_ready[g] = 1'b1;
            end else begin
               e_start = (mcyc == m_acc + 1);
               if (m_resp >= 0 && mcyc == m_resp) begin
                  e_rv[m_id] = 1'b1;
                  e_data     = m_err ? '0 : m_prod;
                  e_err      = m_err;
                  e_rst      = m_err;
               end
            end
            chk("req_ready", req_ready, e_ready);
            chk("rsp_valid", rsp_valid, e_rv);
            chk("rsp_data",  rsp_data,  e_data);
            chk("rsp_err",   rsp_err,   e_err);
            chk("mul_start", mul_start, e_start);
            chk("mul_rst",   mul_rst,   e_rst);
            chk("mul_a",     mul_a,     m_a);
            chk("mul_b",     mul_b,     m_b);
            chk("busy",      busy,      m_busy);
            if (!m_busy) begin
               if (g >= 0) begin
                  m_busy = 1'b1; m_acc = mcyc; m_id = g; m_resp = -1;
                  m_a    = req_a[g*W +: W];
                  m_b    = req_b[g*W +: W];
                  m_ptr  = (g + 1) % N;
               end
            end else if (m_resp < 0) begin
               if (mcyc >= m_acc + 2) begin
                  if (mul_done) begin
                     m_resp = mcyc + 1; m_prod = mul_product; m_err = 1'b0;
                  end else if (mcyc == m_acc + 1 + TMO) begin
                     m_resp = mcyc + 1; m_err = 1'b1;
                  end
               end
            end else if (mcyc == m_resp) begin
               m_busy = 1'b0;
            end
            mcyc++;
         end
      end
   end

   // ---------------- directed + random stimulus
   task automatic wait_rsp(input int maxc, input string nm,
                           output logic [N-1:0] v, output logic [PW-1:0] d, output logic e);
      v = '0; d = '0; e = 1'b0;
      for (int c = 0; c < maxc; c++) begin
         @(negedge clk);
         if (rsp_valid != 0) begin
            v = rsp_valid; d = rsp_data; e = rsp_err;
            return;
         end
      end
      checks++;
      failures++;
      $display("FAIL %s: no response within %0d cycles", nm, maxc);
   endtask

   task automatic wait_ready(input int idx, input int maxc, input string nm);
      for (int c = 0; c < maxc; c++) begin
         @(negedge clk);
         if (req_ready[idx]) return;
      end
      checks++;
      failures++;
      $display("FAIL %s: no req_ready within %0d cycles", nm, maxc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      logic [N-1:0]  v;
      logic [PW-1:0] d;
      logic          e;
      int            base, t_acc, total, target;
      int            exp_id [4];
      logic [PW-1:0] exp_d  [4];

      repeat (3) @(negedge clk);
      chk("init_busy",      busy,      0);
      chk("init_rsp_valid", rsp_valid, 0);
      #2 rst_n = 1'b1;

      // single request 3*5
      fix_a[0] = 4'd3; fix_b[0] = 4'd5; req_tot[0]++;
      wait_rsp(100, "t1", v, d, e);
      chk("t1_valid", v, 4'b0001);
      chk("t1_data",  d, 8'd15);
      chk("t1_err",   e, 1'b0);

      // all four held, fresh pointer
      do_reset();
      base = start_cnt;
      for (int i = 0; i < N; i++) begin
         fix_a[i] = W'(i + 1); fix_b[i] = 4'd2; req_tot[i]++;
      end
      exp_id = '{0, 1, 2, 3};
      exp_d  = '{8'd2, 8'd4, 8'd6, 8'd8};
      for (int k = 0; k < 4; k++) begin
         wait_rsp(100, "t2", v, d, e);
         chk("t2_id",   oh_idx(v), exp_id[k]);
         chk("t2_data", d, exp_d[k]);
      end
      chk("t2_starts", start_cnt - base, 4);

      // fairness between requester 0 and 2
      do_reset();
      fix_a[0] = 4'd1; fix_b[0] = 4'd1; req_tot[0] += 3;
      fix_a[2] = 4'd2; fix_b[2] = 4'd3; req_tot[2] += 3;
      exp_id = '{0, 2, 0, 2};
      exp_d  = '{8'd1, 8'd6, 8'd1, 8'd6};
      for (int k = 0; k < 6; k++) begin
         wait_rsp(100, "t3", v, d, e);
         if (k < 4) begin
            chk("t3_id",   oh_idx(v), exp_id[k]);
            chk("t3_data", d, exp_d[k]);
         end
      end

      // watchdog abort, then recovery
      hang = 1'b1;
      fix_a[0] = 4'd7; fix_b[0] = 4'd3; req_tot[0]++;
      wait_ready(0, 50, "t4_ready");
      t_acc = tcyc;
      wait_rsp(100, "t4", v, d, e);
      chk("t4_latency", tcyc - t_acc, TMO + 2);
      chk("t4_valid",   v, 4'b0001);
      chk("t4_data",    d, 0);
      chk("t4_err",     e, 1'b1);
      chk("t4_mul_rst", mul_rst, 1'b1);
      hang = 1'b0;
      fix_a[1] = 4'd2; fix_b[1] = 4'd3; req_tot[1]++;
      wait_rsp(100, "t4b", v, d, e);
      chk("t4b_valid", v, 4'b0010);
      chk("t4b_data",  d, 8'd6);
      chk("t4b_err",   e, 1'b0);

      // async reset during WAIT
      lat_fixed = 14;
      fix_a[3] = 4'd5; fix_b[3] = 4'd5; req_tot[3]++;
      wait_ready(3, 50, "t5_ready");
      repeat (4) @(negedge clk);
      chk("t5_busy_before", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_busy",      busy,      0);
      chk("t5_mul_a",     mul_a,     0);
      chk("t5_mul_b",     mul_b,     0);
      chk("t5_rsp_valid", rsp_valid, 0);
      chk("t5_req_ready", req_ready, 0);
      chk("t5_mul_start", mul_start, 0);
      chk("t5_mul_rst",   mul_rst,   0);
      chk("t5_rsp_data",  rsp_data,  0);
      chk("t5_rsp_err",   rsp_err,   0);
      lat_fixed = 0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      base = rsp_cnt;
      repeat (30) @(negedge clk);
      chk("t5_no_rsp", rsp_cnt - base, 0);

      // spurious done while idle
      base = rsp_cnt;
      @(posedge clk); #1 spur = 1'b1;
      @(posedge clk); #1 spur = 1'b0;
      repeat (3) @(negedge clk);
      chk("t6_busy",   busy, 0);
      chk("t6_no_rsp", rsp_cnt - base, 0);
      fix_a[2] = 4'd4; fix_b[2] = 4'd4; req_tot[2]++;
      wait_rsp(100, "t6", v, d, e);
      chk("t6_valid", v, 4'b0100);
      chk("t6_data",  d, 8'h10);

      // randomized traffic with withdrawals and random core latency
      rnd_ops = 1'b1;
      withdraw_en = 1'b1;
      total = 0;
      base  = rsp_cnt;
      for (int i = 0; i < N; i++) begin
         int n;
         n = int'($urandom_range(3, 8));
         req_tot[i] += n;
         total += n;
      end
      target = base + total;
      for (int c = 0; c < 8000 && rsp_cnt < target; c++) @(negedge clk);
      repeat (5) @(negedge clk);
      chk("rnd_rsp_count", rsp_cnt - base, total);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not finish, checks=%0d", checks);
      $fatal(1, "global timeout");
   end

endmodule
`default_nettype wire
